// File: rtl/fwd_ctrl_unit_pkg.sv
// Shared types and constants for the EX-stage forwarding / load-use stall unit.
// FWD_LOAD_USE_STALL_EN adds the memread shadow bit used by load-use detection.
package fwd_ctrl_unit_pkg;

    localparam int FWD_REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [FWD_REG_AW-1:0] rs;
        logic [FWD_REG_AW-1:0] rt;
        logic [FWD_REG_AW-1:0] dst;
        logic                  regwrite;
`ifdef FWD_LOAD_USE_STALL_EN
        logic                  memread;
`endif
    } stage_t;

endpackage

// File: rtl/fwd_ctrl_unit_if.sv
// Decode-stage instruction fields in, EX operand selects and stall out.
interface fwd_ctrl_unit_if
    import fwd_ctrl_unit_pkg::*;
#(
    parameter int REG_AW = FWD_REG_AW
) ();

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_dst;
    logic              id_regwrite;
    logic              id_memread;
    logic              flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              stall;

    modport master (
        output id_valid, id_rs, id_rt, id_dst, id_regwrite, id_memread, flush,
        input  fwd_a, fwd_b, stall
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_dst, id_regwrite, id_memread, flush,
        output fwd_a, fwd_b, stall
    );

endinterface

// File: rtl/fwd_ctrl_unit_fwd_match.sv
// One operand's forwarding select: newest matching producer (MEM over WB), never $0.
module fwd_match
    import fwd_ctrl_unit_pkg::*;
(
    input  logic                  en,
    input  logic [FWD_REG_AW-1:0] src,
    input  stage_t                mem_s,
    input  stage_t                wb_s,
    output logic [1:0]            sel
);

    always_comb begin
        sel = FWD_RF;
        if (en) begin
            if (mem_s.valid && mem_s.regwrite && (mem_s.dst != '0) && (mem_s.dst == src))
                sel = FWD_MEM;
            else if (wb_s.valid && wb_s.regwrite && (wb_s.dst != '0) && (wb_s.dst == src))
                sel = FWD_WB;
        end
    end

    // source fields of the older stages only travel along for pipeline bookkeeping
    wire unused_fields = ^{mem_s.rs, mem_s.rt, wb_s.rs, wb_s.rt};
`ifdef FWD_LOAD_USE_STALL_EN
    wire unused_memread = mem_s.memread ^ wb_s.memread;
`endif

endmodule

// File: rtl/fwd_ctrl_unit.sv
// Forwarding and load-use stall control with EX/MEM/WB shadow stages.
// Load-use stall only exists when FWD_LOAD_USE_STALL_EN is defined.
module fwd_ctrl_unit
    import fwd_ctrl_unit_pkg::*;
#(
    parameter int REG_AW = FWD_REG_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    fwd_ctrl_unit_if.slave  bus
);

    stage_t ex_q;
    stage_t mem_q;
    stage_t wb_q;
    logic   stall_c;

    logic [REG_AW-1:0] id_rs_w;
    logic [REG_AW-1:0] id_rt_w;
    logic [REG_AW-1:0] id_dst_w;

    assign id_rs_w  = bus.id_rs;
    assign id_rt_w  = bus.id_rt;
    assign id_dst_w = bus.id_dst;

`ifdef FWD_LOAD_USE_STALL_EN
    // stall looks at the live decode operands, so it resolves in the same cycle
    assign stall_c = ex_q.valid && ex_q.memread && (ex_q.dst != '0) && bus.id_valid &&
                     ((ex_q.dst == id_rs_w) || (ex_q.dst == id_rt_w));
`else
    assign stall_c = 1'b0;
    wire unused_memread = bus.id_memread;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (bus.id_valid && !stall_c && !bus.flush) begin
                ex_q.valid    <= 1'b1;
                ex_q.rs       <= id_rs_w;
                ex_q.rt       <= id_rt_w;
                ex_q.dst      <= id_dst_w;
                ex_q.regwrite <= bus.id_regwrite;
`ifdef FWD_LOAD_USE_STALL_EN
                ex_q.memread  <= bus.id_memread;
`endif
            end else begin
                ex_q <= '0;
            end
        end
    end

    fwd_match u_match_a (
        .en    (ex_q.valid),
        .src   (ex_q.rs),
        .mem_s (mem_q),
        .wb_s  (wb_q),
        .sel   (bus.fwd_a)
    );

    fwd_match u_match_b (
        .en    (ex_q.valid),
        .src   (ex_q.rt),
        .mem_s (mem_q),
        .wb_s  (wb_q),
        .sel   (bus.fwd_b)
    );

    assign bus.stall = stall_c;

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Table-driven bench for fwd_ctrl_unit; expectations follow FWD_LOAD_USE_STALL_EN.
module tb_fwd_ctrl_unit;

    typedef struct {
        string      name;
        logic       v;
        logic [4:0] rs, rt, dst;
        logic       rw, mr, fl;
        logic [1:0] ea, eb;
        logic       es;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] a, b;
        logic       s;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    fwd_ctrl_unit_if #(.REG_AW(5)) bus ();

    fwd_ctrl_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic vec_t mk(string n, logic v, int rs, int rt, int dst, logic rw, logic mr,
                                logic fl, logic [1:0] ea, logic [1:0] eb, logic es);
        vec_t t;
        t.name = n; t.v = v;
        t.rs = 5'(rs); t.rt = 5'(rt); t.dst = 5'(dst);
        t.rw = rw; t.mr = mr; t.fl = fl;
        t.ea = ea; t.eb = eb; t.es = es;
        return t;
    endfunction

    task automatic compare(exp_t e);
        n_vec++;
        if (bus.fwd_a !== e.a || bus.fwd_b !== e.b || bus.stall !== e.s) begin
            n_err++;
            $display("FAIL %s: got fwd_a=%b fwd_b=%b stall=%b, expected fwd_a=%b fwd_b=%b stall=%b",
                     e.name, bus.fwd_a, bus.fwd_b, bus.stall, e.a, e.b, e.s);
        end
    endtask

    // drive on the falling edge, check 1ns later: outputs reflect the EX
    // occupant from the previous rising edge and the decode fields just driven
    task automatic apply(vec_t t);
        @(negedge clk);
        bus.id_valid    = t.v;
        bus.id_rs       = t.rs;
        bus.id_rt       = t.rt;
        bus.id_dst      = t.dst;
        bus.id_regwrite = t.rw;
        bus.id_memread  = t.mr;
        bus.flush       = t.fl;
        sb.push_back('{t.name, t.ea, t.eb, t.es});
        #1;
        compare(sb.pop_front());
    endtask

    initial begin
        bus.id_valid = 1'b1; bus.id_rs = 5'd3; bus.id_rt = 5'd3; bus.id_dst = 5'd3;
        bus.id_regwrite = 1'b1; bus.id_memread = 1'b1; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        compare('{"in_reset", 2'b00, 2'b00, 1'b0});
        bus.id_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        //          name         v  rs rt dst rw mr fl  ea     eb     es
        vecs.push_back(mk("mem_a0",   1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("mem_a1",   1, 3, 4, 5, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("mem_a2",   0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0));
        vecs.push_back(mk("wb_b0",    1, 1, 1, 3, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("wb_b1",    0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("wb_b2",    1, 2, 3, 6, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("wb_b3",    0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0));
        vecs.push_back(mk("newest0",  1, 1, 1, 3, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("newest1",  1, 2, 2, 3, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("newest2",  1, 3, 3, 7, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("newest3",  0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 0));
        vecs.push_back(mk("r0_0",     1, 1, 2, 0, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("r0_1",     1, 0, 0, 4, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("r0_mem",   1, 0, 0, 9, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("r0_wb",    0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("norw0",    1, 1, 2, 10, 0, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("norw1",    1, 10, 10, 11, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("norw2",    0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("flush0",   1, 1, 1, 12, 1, 0, 1, 2'b00, 2'b00, 0));
        vecs.push_back(mk("flush1",   1, 12, 12, 13, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("flush2",   0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("lw0",      1, 1, 0, 8, 1, 1, 0, 2'b00, 2'b00, 0));
`ifdef FWD_LOAD_USE_STALL_EN
        vecs.push_back(mk("lu_stall", 1, 8, 1, 9, 1, 0, 0, 2'b00, 2'b00, 1));
        vecs.push_back(mk("lu_held",  1, 8, 1, 9, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("lu_fwd",   0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0));
        vecs.push_back(mk("fs_lw",    1, 1, 0, 8, 1, 1, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("fs_both",  1, 1, 8, 9, 1, 0, 1, 2'b00, 2'b00, 1));
        vecs.push_back(mk("fs_after", 1, 8, 8, 14, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("fs_fwd",   0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0));
`else
        vecs.push_back(mk("lu_nostl", 1, 8, 1, 9, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("lu_mem",   0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0));
`endif
        vecs.push_back(mk("rst_pre0", 1, 1, 1, 3, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("rst_pre1", 1, 3, 3, 5, 1, 0, 0, 2'b00, 2'b00, 0));
        vecs.push_back(mk("rst_pre2", 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // add $3 now in MEM; reset must clear selects without waiting for a clock
        #1 rst_n = 1'b0;
        #1 compare('{"rst_async", 2'b00, 2'b00, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk("post_rst0", 1, 3, 3, 6, 1, 0, 0, 2'b00, 2'b00, 0));
        apply(mk("post_rst1", 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fwd_ctrl_unit.md
FWD_CTRL_UNIT -- requirements
Module: fwd_ctrl_unit

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 clk  input  1  pipeline clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 id_valid  input  1  decode-stage instruction valid.
REQ-005 id_rs  input  REG_AW  decode-stage source register A.
REQ-006 id_rt  input  REG_AW  decode-stage source register B.
REQ-007 id_dst  input  REG_AW  decode-stage destination register.
REQ-008 id_regwrite  input  1  decode-stage instruction writes the register file.
REQ-009 id_memread  input  1  decode-stage instruction is a load.
REQ-010 flush  input  1  kill the decode-stage instruction (branch taken).
REQ-011 fwd_a  output  2  EX operand-A select: 00 register file, 01 MEM/WB, 10 EX/MEM; 11 never driven.
REQ-012 fwd_b  output  2  EX operand-B select, same encoding; bit 0 and bit 1 are consumed separately by the datapath muxes.
REQ-013 stall  output  1  hold PC and IF/ID, insert bubble into EX.

Function
REQ-014 Unit SHALL hold three shadow stages (EX, MEM, WB), each: valid, rs, rt, dst, regwrite, memread.
REQ-015 Each cycle MEM<-EX and WB<-MEM unconditionally.
REQ-016 EX<-decode fields when id_valid=1, stall=0, flush=0; otherwise EX.valid<=0 (bubble).
REQ-017 fwd_a SHALL be 10 when MEM.valid, MEM.regwrite, MEM.dst!=0, MEM.dst==EX.rs.
REQ-018 Else fwd_a SHALL be 01 when WB.valid, WB.regwrite, WB.dst!=0, WB.dst==EX.rs.
REQ-019 Else fwd_a SHALL be 00; fwd_b identical using EX.rt.
REQ-020 fwd_a/fwd_b SHALL be 00 whenever EX.valid=0.
REQ-021 Simultaneous MEM and WB match: MEM (newest) wins, select 10.
REQ-022 Register 0 SHALL never be forwarded, regardless of regwrite.
REQ-023 fwd_a/fwd_b SHALL be combinational from shadow registers only (zero latency to EX muxes, no path from id_* inputs).
REQ-024 stall SHALL be 1 when EX.valid, EX.memread, EX.dst!=0, id_valid, and EX.dst equals id_rs or id_rt; else 0.
REQ-025 Stall lasts exactly one cycle per load-use pair (load moves to MEM, condition clears).
REQ-026 flush and stall together: flush wins for EX entry (bubble); stall still asserted that cycle.
REQ-027 Back-to-back load then dependent ALU op SHALL yield stall then fwd select 01 on the dependent op in EX.

Reset
REQ-028 rst_n low SHALL asynchronously clear all valid bits and all shadow fields to 0.
REQ-029 During and after reset until first valid instruction: fwd_a=00, fwd_b=00, stall=0.
REQ-030 Reset mid-operation SHALL discard all in-flight shadow state; no forward select derived from pre-reset contents.

Configuration
REQ-031 Macro FWD_LOAD_USE_STALL_EN defined: load-use detection per REQ-024..REQ-027.
REQ-032 Macro undefined: stall tied 0, memread shadow bits removed, EX always accepts decode fields subject only to id_valid/flush; forwarding unchanged.

Structure
REQ-033 Shared package SHALL hold REG_AW default, fwd select constants (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and the shadow-stage record typedef.
REQ-034 One sub-module fwd_match SHALL compute one 2-bit select from one source address plus MEM/WB shadow fields; instantiated twice (A, B).
REQ-035 No other sub-modules; shadow registers live in the top.

Verification
REQ-036 add $3 then add $5,$3,$4 back-to-back -> second op in EX: fwd_a=10, fwd_b=00.
REQ-037 add $3; nop; sub $6,$2,$3 -> sub in EX: fwd_a=00, fwd_b=01.
REQ-038 add $3; add $3; or $7,$3,$3 -> or in EX: fwd_a=10, fwd_b=10 (newest wins).
REQ-039 lw $8; add $9,$8,$1 with macro defined -> stall=1 one cycle, bubble in EX, then add in EX with fwd_a=01; macro undefined -> stall stays 0.
REQ-040 add $0,$1,$2; add $4,$0,$0 -> fwd_a=00, fwd_b=00.
REQ-041 rst_n pulsed low mid-stream with add $3 in MEM -> outputs 00/00/0 immediately; next instruction reading $3 gets fwd_a=00.
